// File: rtl/seq_fixed_point_sin_range_reduce.sv
// Iterative modulo-2pi range reducer feeding the CORDIC sine core: folds any angle into [0, pi/2] plus a negate flag.
// Optional cosine-target outputs are enabled with `define FPSIN_RANGE_COS_EN.
module seq_fixed_point_sin_range_reduce #(
    parameter int WII   = 4,
    parameter int WIF   = 8,
    parameter int WOI   = 4,
    parameter int WOF   = 8,
    parameter int ROUND = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [WII+WIF-1:0]   i_angle,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [WOI+WOF-1:0]   o_target,
    output logic                 o_neg
`ifdef FPSIN_RANGE_COS_EN
    ,
    output logic [WOI+WOF-1:0]   o_cos_target,
    output logic                 o_cos_neg
`endif
);

    localparam int WI  = WII + WIF;
    localparam int WO  = WOI + WOF;
    localparam int WRI = WII + 3;
    localparam int WRF = (WIF > WOF) ? WIF : WOF;
    localparam int W   = WRI + WRF;
    localparam int KW  = (WII > 1) ? $clog2(WII) : 1;
    localparam int RSH = 28 - WRF;
    localparam int SH  = WRF - WOF;

    // Q4.28 reference constant rounded to nearest into WRF fraction bits
    function automatic logic [W-1:0] q28(input logic [63:0] v);
        return W'((v + ((64'd1 << RSH) >> 1)) >> RSH);
    endfunction

    localparam logic [W-1:0] C_2PI = q28(64'h6487ED51);
    localparam logic [W-1:0] C_PI  = q28(64'h3243F6A9);
    localparam logic [W-1:0] C_PIH = q28(64'h1921FB54);
    localparam logic [W-1:0] C_P3H = q28(64'h4B65F1FD);

    function automatic logic [WO-1:0] cvt(input logic [W-1:0] v);
        logic [W-1:0] x;
        x = v;
        if (ROUND != 0) x = v + ((W'(1) << SH) >> 1);
        return WO'(x >> SH);
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_REDUCE, S_FOLD, S_DONE} state_t;

    state_t         r_state, w_state_nxt;
    logic           r_s;
    logic [W-1:0]   r_a;
    logic [KW-1:0]  r_k;
    logic           r_valid;
    logic [WO-1:0]  r_target;
    logic           r_neg;

    logic [W-1:0]   w_ext, w_abs, w_sub, w_a_nxt, w_r, w_t;
    logic           w_neg;

    // Sign-extend first so the most negative input has headroom when negated
    assign w_ext   = {{(W-WI){i_angle[WI-1]}}, i_angle} << (WRF - WIF);
    assign w_abs   = i_angle[WI-1] ? (W'(0) - w_ext) : w_ext;
    assign w_sub   = C_2PI << r_k;
    assign w_a_nxt = (r_a >= w_sub) ? (r_a - w_sub) : r_a;
    assign w_r     = (r_s && (r_a != '0)) ? (C_2PI - r_a) : r_a;

    always_comb begin
        w_t   = w_r;
        w_neg = 1'b0;
        if (w_r < C_PIH) begin
            w_t   = w_r;
            w_neg = 1'b0;
        end else if (w_r < C_PI) begin
            w_t   = C_PI - w_r;
            w_neg = 1'b0;
        end else if (w_r < C_P3H) begin
            w_t   = w_r - C_PI;
            w_neg = 1'b1;
        end else begin
            w_t   = C_2PI - w_r;
            w_neg = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (i_valid) w_state_nxt = S_REDUCE;
            S_REDUCE: if (r_k == '0) w_state_nxt = S_FOLD;
            S_FOLD:   w_state_nxt = S_DONE;
            S_DONE:   if (o_ready) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s      <= 1'b0;
            r_a      <= '0;
            r_k      <= '0;
            r_valid  <= 1'b0;
            r_target <= '0;
            r_neg    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (i_valid) begin
                    r_s <= i_angle[WI-1];
                    r_a <= w_abs;
                    r_k <= KW'(WII - 1);
                end
                S_REDUCE: begin
                    r_a <= w_a_nxt;
                    r_k <= r_k - KW'(1);
                end
                S_FOLD: begin
                    r_target <= cvt(w_t);
                    r_neg    <= w_neg;
                    r_valid  <= 1'b1;
                end
                S_DONE: if (o_ready) r_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign i_ready  = (r_state == S_IDLE);
    assign o_valid  = r_valid;
    assign o_target = r_target;
    assign o_neg    = r_neg;

`ifdef FPSIN_RANGE_COS_EN
    logic [WO-1:0]  r_cos_target;
    logic           r_cos_neg;
    logic [W-1:0]   w_cos_t;

    // cos(r) = sin(r + pi/2): its fold target is the complement of the sine target
    assign w_cos_t = C_PIH - w_t;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cos_target <= '0;
            r_cos_neg    <= 1'b0;
        end else if (r_state == S_FOLD) begin
            r_cos_target <= cvt(w_cos_t);
            r_cos_neg    <= (w_r >= C_PIH) && (w_r < C_P3H);
        end
    end

    assign o_cos_target = r_cos_target;
    assign o_cos_neg    = r_cos_neg;
`endif

endmodule

// File: tb/tb_seq_fixed_point_sin_range_reduce.sv
// Directed bench for the range reducer at default parameters (Q4.8 in, Q4.8 out, 2pi = 0x648).
module tb_seq_fixed_point_sin_range_reduce;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_valid;
    logic        i_ready;
    logic [11:0] i_angle;
    logic        o_valid;
    logic        o_ready;
    logic [11:0] o_target;
    logic        o_neg;
`ifdef FPSIN_RANGE_COS_EN
    logic [11:0] o_cos_target;
    logic        o_cos_neg;
`endif

    int n_pass  = 0;
    int n_total = 0;

    seq_fixed_point_sin_range_reduce dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_valid      (i_valid),
        .i_ready      (i_ready),
        .i_angle      (i_angle),
        .o_valid      (o_valid),
        .o_ready      (o_ready),
        .o_target     (o_target),
        .o_neg        (o_neg)
`ifdef FPSIN_RANGE_COS_EN
        ,
        .o_cos_target (o_cos_target),
        .o_cos_neg    (o_cos_neg)
`endif
    );

    always #5 clk = ~clk;

    // One transaction with o_ready held high. lat counts cycles from the
    // handshake cycle (cycle 0) to the first cycle o_valid is seen; 40 = timeout.
    task automatic xact(input logic [11:0] ang, output logic [11:0] tgt,
                        output logic ng, output int lat);
        @(negedge clk);
        i_angle = ang;
        i_valid = 1'b1;
        o_ready = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        lat = 1;
        while (o_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        tgt = o_target;
        ng  = o_neg;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rstn = 1'b0; i_valid = 1'b0; i_angle = '0; o_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_total++; if (o_valid !== 1'b0) $display("FAIL rst_o_valid got %b want 0", o_valid); else n_pass++;
        n_total++; if (o_target !== 12'h000) $display("FAIL rst_o_target got %h want 000", o_target); else n_pass++;
        n_total++; if (o_neg !== 1'b0) $display("FAIL rst_o_neg got %b want 0", o_neg); else n_pass++;
        n_total++; if (i_ready !== 1'b1) $display("FAIL rst_i_ready got %b want 1", i_ready); else n_pass++;
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [11:0] t; logic n; int lat;
        xact(12'h100, t, n, lat);
        n_total++; if (lat != 6) $display("FAIL basic_latency got %0d want 6", lat); else n_pass++;
        n_total++; if (t !== 12'h100) $display("FAIL basic_target got %h want 100", t); else n_pass++;
        n_total++; if (n !== 1'b0) $display("FAIL basic_neg got %b want 0", n); else n_pass++;
    endtask

    task automatic test_quadrants;
        logic [11:0] ang [5] = '{12'h300, 12'hF00, 12'h700, 12'h500, 12'hD00};
        logic [11:0] exp_t [5] = '{12'h024, 12'h100, 12'h0B8, 12'h148, 12'h024};
        logic        exp_n [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [11:0] t; logic n; int lat;
        for (int i = 0; i < 5; i++) begin
            xact(ang[i], t, n, lat);
            n_total++; if (lat != 6) $display("FAIL quad_latency[%h] got %0d want 6", ang[i], lat); else n_pass++;
            n_total++; if (t !== exp_t[i]) $display("FAIL quad_target[%h] got %h want %h", ang[i], t, exp_t[i]); else n_pass++;
            n_total++; if (n !== exp_n[i]) $display("FAIL quad_neg[%h] got %b want %b", ang[i], n, exp_n[i]); else n_pass++;
        end
    endtask

    task automatic test_most_negative;
        logic [11:0] t; logic n; int lat;
        xact(12'h800, t, n, lat);
        n_total++; if (t !== 12'h16C) $display("FAIL mostneg_target got %h want 16c", t); else n_pass++;
        n_total++; if (n !== 1'b1) $display("FAIL mostneg_neg got %b want 1", n); else n_pass++;
    endtask

    task automatic test_boundaries;
        logic [11:0] ang [5] = '{12'h192, 12'h324, 12'h000, 12'h648, 12'hE6E};
        logic [11:0] exp_t [5] = '{12'h192, 12'h000, 12'h000, 12'h000, 12'h192};
        logic        exp_n [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [11:0] t; logic n; int lat;
        for (int i = 0; i < 5; i++) begin
            xact(ang[i], t, n, lat);
            n_total++; if (t !== exp_t[i]) $display("FAIL bound_target[%h] got %h want %h", ang[i], t, exp_t[i]); else n_pass++;
            n_total++; if (n !== exp_n[i]) $display("FAIL bound_neg[%h] got %b want %b", ang[i], n, exp_n[i]); else n_pass++;
        end
    endtask

    task automatic test_backpressure;
        int  wait_cyc;
        logic stray;
        @(negedge clk);
        i_angle = 12'h300; i_valid = 1'b1; o_ready = 1'b0;
        @(negedge clk);
        i_valid = 1'b0;
        wait_cyc = 1;
        while (o_valid !== 1'b1 && wait_cyc < 40) begin
            @(negedge clk);
            wait_cyc++;
        end
        n_total++; if (wait_cyc != 6) $display("FAIL bp_latency got %0d want 6", wait_cyc); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            n_total++; if (o_valid !== 1'b1) $display("FAIL bp_hold_valid[%0d] got %b want 1", i, o_valid); else n_pass++;
            n_total++; if (o_target !== 12'h024) $display("FAIL bp_hold_target[%0d] got %h want 024", i, o_target); else n_pass++;
            n_total++; if (o_neg !== 1'b0) $display("FAIL bp_hold_neg[%0d] got %b want 0", i, o_neg); else n_pass++;
            n_total++; if (i_ready !== 1'b0) $display("FAIL bp_i_ready[%0d] got %b want 0", i, i_ready); else n_pass++;
            i_valid = i[0];
            i_angle = 12'h700;
            @(negedge clk);
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        @(negedge clk);
        n_total++; if (o_valid !== 1'b0) $display("FAIL bp_release_valid got %b want 0", o_valid); else n_pass++;
        n_total++; if (i_ready !== 1'b1) $display("FAIL bp_release_ready got %b want 1", i_ready); else n_pass++;
        stray = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (o_valid !== 1'b0 || i_ready !== 1'b1) stray = 1'b1;
        end
        n_total++; if (stray !== 1'b0) $display("FAIL bp_pulse_not_queued got %b want 0", stray); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int first, second;
        first = -1; second = -1;
        @(negedge clk);
        o_ready = 1'b1; i_angle = 12'h100; i_valid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (i_ready === 1'b1) begin
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
            @(negedge clk);
        end
        i_valid = 1'b0;
        repeat (12) @(negedge clk);
        n_total++; if (first != 0) $display("FAIL b2b_first_accept got %0d want 0", first); else n_pass++;
        n_total++; if (second - first != 7) $display("FAIL b2b_interval got %0d want 7", second - first); else n_pass++;
    endtask

    task automatic test_reset_mid;
        logic [11:0] t; logic n; int lat;
        logic stray;
        xact(12'h800, t, n, lat);
        @(negedge clk);
        i_angle = 12'h700; i_valid = 1'b1; o_ready = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        n_total++; if (o_valid !== 1'b0) $display("FAIL mrst_o_valid got %b want 0", o_valid); else n_pass++;
        n_total++; if (o_target !== 12'h000) $display("FAIL mrst_o_target got %h want 000", o_target); else n_pass++;
        n_total++; if (o_neg !== 1'b0) $display("FAIL mrst_o_neg got %b want 0", o_neg); else n_pass++;
        n_total++; if (i_ready !== 1'b1) $display("FAIL mrst_i_ready got %b want 1", i_ready); else n_pass++;
        @(negedge clk);
        rstn = 1'b1;
        stray = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (o_valid !== 1'b0) stray = 1'b1;
        end
        n_total++; if (stray !== 1'b0) $display("FAIL mrst_aborted got %b want 0", stray); else n_pass++;
        xact(12'h100, t, n, lat);
        n_total++; if (lat != 6) $display("FAIL mrst_latency got %0d want 6", lat); else n_pass++;
        n_total++; if (t !== 12'h100) $display("FAIL mrst_target got %h want 100", t); else n_pass++;
        n_total++; if (n !== 1'b0) $display("FAIL mrst_neg got %b want 0", n); else n_pass++;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_quadrants;
        test_most_negative;
        test_boundaries;
        test_backpressure;
        test_back_to_back;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
